// File: rtl/game_screen_seq.sv
// Game-screen sequencer: tracks idle/play/win/lose, keeps the score, and drives
// the banner overlay enables with a frame-synchronous blink and hold timeout.
module game_screen_seq #(
  parameter int WIN_SCORE    = 20,
  parameter int SCORE_W      = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 300
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               start,
  input  logic               food_eaten,
  input  logic               collision,
  output logic [SCORE_W-1:0] score_out,
  output logic               game_reset,
  output logic               game_run,
  output logic               victory,
  output logic               defeat,
  output logic               banner_on,
  output logic [1:0]         state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_SCORE_V = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_M1      = SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
  localparam logic [15:0]        BLINK_LAST  = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0]        HOLD_LAST   = 16'(HOLD_FRAMES - 1);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [15:0]        blink_cnt_q, blink_cnt_d;
  logic               banner_q, banner_d;
  logic               vsync_d_q, vsync_d_d;
  logic               start_d_q, start_d_d;

  logic frame_tick;
  logic start_edge;
  logic enter_end;
  logic go_idle;

  assign frame_tick = vsync_in & ~vsync_d_q;
  assign start_edge = start & ~start_d_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      banner_q    <= 1'b0;
      vsync_d_q   <= 1'b0;
      start_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      banner_q    <= banner_d;
      vsync_d_q   <= vsync_d_d;
      start_d_q   <= start_d_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    banner_d    = banner_q;
    vsync_d_d   = vsync_in;
    start_d_d   = start;
    enter_end   = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        score_d     = '0;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        banner_d    = 1'b0;
        if (start_edge) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Collision wins over a same-cycle food pulse and freezes the score.
        if (collision) begin
          state_d   = S_LOSE;
          enter_end = 1'b1;
        end else if (food_eaten) begin
          if (score_q == WIN_M1) begin
            score_d   = WIN_SCORE_V;
            state_d   = S_WIN;
            enter_end = 1'b1;
          end else begin
            score_d = score_q + SCORE_ONE;
          end
        end
      end
      default: begin
        if (start_edge) begin
          go_idle = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt_q == HOLD_LAST) begin
            go_idle = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              banner_d    = ~banner_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 16'd1;
            end
          end
        end
      end
    endcase

    if (enter_end) begin
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      banner_d    = 1'b1;
    end

    if (go_idle) begin
      state_d     = S_IDLE;
      score_d     = '0;
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      banner_d    = 1'b0;
    end
  end

  assign score_out  = score_q;
  assign game_reset = (state_q == S_IDLE);
  assign game_run   = (state_q == S_PLAY);
  assign victory    = (state_q == S_WIN);
  assign defeat     = (state_q == S_LOSE);
  assign banner_on  = banner_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_game_screen_seq.sv
// Bench for game_screen_seq: directed scenarios plus random play, every cycle's
// outputs compared against a phase/score/tick-count reference model.
module tb_game_screen_seq;

  localparam int WIN_SCORE    = 3;
  localparam int SCORE_W      = 8;
  localparam int BLINK_FRAMES = 2;
  localparam int HOLD_FRAMES  = 6;
  localparam int W            = 2 + SCORE_W + 5;

  logic               pclk = 1'b0;
  logic               rst = 1'b1;
  logic               vsync_in = 1'b0;
  logic               start = 1'b0;
  logic               food_eaten = 1'b0;
  logic               collision = 1'b0;
  logic [SCORE_W-1:0] score_out;
  logic               game_reset;
  logic               game_run;
  logic               victory;
  logic               defeat;
  logic               banner_on;
  logic [1:0]         state_out;

  game_screen_seq #(
    .WIN_SCORE   (WIN_SCORE),
    .SCORE_W     (SCORE_W),
    .BLINK_FRAMES(BLINK_FRAMES),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .start     (start),
    .food_eaten(food_eaten),
    .collision (collision),
    .score_out (score_out),
    .game_reset(game_reset),
    .game_run  (game_run),
    .victory   (victory),
    .defeat    (defeat),
    .banner_on (banner_on),
    .state_out (state_out)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rst_next = 1'b1;

  // Reference model: phase 0=idle 1=play 2=win 3=lose; m_k = frame ticks since entry
  int m_phase = 0;
  int m_score = 0;
  int m_k     = 0;
  bit m_vs_d  = 1'b0;
  bit m_st_d  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [1:0]         p;
    logic [SCORE_W-1:0] s;
    logic               b;
    p = m_phase[1:0];
    s = m_score[SCORE_W-1:0];
    b = (m_phase >= 2) ? (((m_k / BLINK_FRAMES) % 2) == 0) : 1'b0;
    return {p, s, m_phase == 0, m_phase == 1, m_phase == 2, m_phase == 3, b};
  endfunction

  task automatic model_update(input bit r, input bit vs, input bit st, input bit fe, input bit col);
    bit tick, sedge;
    if (r) begin
      m_phase = 0; m_score = 0; m_k = 0; m_vs_d = 0; m_st_d = 0;
      return;
    end
    tick  = vs && !m_vs_d;
    sedge = st && !m_st_d;
    case (m_phase)
      0: if (sedge) m_phase = 1;
      1: begin
        if (col) begin
          m_phase = 3; m_k = 0;
        end else if (fe) begin
          m_score++;
          if (m_score == WIN_SCORE) begin
            m_phase = 2; m_k = 0;
          end
        end
      end
      default: begin
        if (sedge) begin
          m_phase = 0; m_score = 0; m_k = 0;
        end else if (tick) begin
          m_k++;
          if (m_k == HOLD_FRAMES) begin
            m_phase = 0; m_score = 0; m_k = 0;
          end
        end
      end
    endcase
    m_vs_d = vs;
    m_st_d = st;
  endtask

  // Driver: one call per clock; inputs change on the falling edge
  task automatic step(input logic vs, input logic st, input logic fe, input logic col);
    @(negedge pclk);
    rst        = rst_next;
    vsync_in   = vs;
    start      = st;
    food_eaten = fe;
    collision  = col;
    model_update(rst_next, vs, st, fe, col);
    exp_q.push_back(model_out());
    @(posedge pclk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},      32'(state_out),  32'd0);
    check({tag, "_score"},      32'(score_out),  32'd0);
    check({tag, "_game_reset"}, 32'(game_reset), 32'd1);
    check({tag, "_game_run"},   32'(game_run),   32'd0);
    check({tag, "_victory"},    32'(victory),    32'd0);
    check({tag, "_defeat"},     32'(defeat),     32'd0);
    check({tag, "_banner"},     32'(banner_on),  32'd0);
  endtask

  // Monitor: compares every registered output snapshot shortly after the edge
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state_out, score_out, game_reset, game_run, victory, defeat, banner_on};
        check("outputs", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    logic st_lvl;
    #2;
    check_reset_values("in_reset");
    repeat (2) step(0, 0, 0, 0);
    rst_next = 1'b0;
    repeat (2) step(0, 0, 0, 0);

    // start rises, then held high: one transition only
    repeat (5) step(0, 1, 0, 0);

    // win path: three food pulses, then inputs ignored in WIN
    repeat (3) begin
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
    end
    repeat (2) step(0, 1, 0, 0);
    step(0, 1, 1, 1);

    // early exit: start edge coincident with frame tick, then a new start
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // score 2, then food and collision together
    repeat (2) begin
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
    end
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);

    // blink and hold in LOSE across six frame ticks, then stay idle with start held
    repeat (6) begin
      repeat (2) step(1, 1, 0, 0);
      repeat (3) step(0, 1, 0, 0);
    end
    repeat (3) step(0, 1, 0, 0);

    // mid-game asynchronous reset
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (2) begin
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
    end
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    rst_next = 1'b1;
    repeat (2) step(0, 1, 0, 0);
    rst_next = 1'b0;
    repeat (3) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end

    // random play
    st_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) st_lvl = ~st_lvl;
      rst_next = ($urandom_range(0, 999) == 0);
      step(((c % 8) < 2) ? 1'b1 : 1'b0, st_lvl,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end
    rst_next = 1'b0;
    repeat (3) step(0, 0, 0, 0);

    @(posedge pclk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
